muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 16 +
 rtl/muldiv_seq.sv | 88 ++++++++
 tb/tb_muldiv_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle of the sequential multiply/divide unit.
interface muldiv_seq_if #(parameter int XLEN = 32);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] src_a_i;
    logic [XLEN-1:0] src_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    modport master (output start_i, funct3_i, src_a_i, src_b_i, flush_i,
                    input  busy_o, stall_o, done_o, result_o);
    modport slave  (input  start_i, funct3_i, src_a_i, src_b_i, flush_i,
                    output busy_o, stall_o, done_o, result_o);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, shift-add / restoring divide on magnitudes,
// sign fix-up in one extra cycle; fixed 34-cycle latency from accept to Done.
module muldiv_seq #(parameter int XLEN = 32) (
    input logic        clk,
    input logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   m_q;
    logic [2*XLEN:0]   acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              sgn_a, sgn_b, neg_a, neg_b, accept;
    logic [XLEN-1:0]   mag_a, mag_b, quo, rem, quo_s, rem_s, res;
    logic [XLEN:0]     mul_sum, r_sh;
    logic [XLEN+1:0]   diff;
    logic              ge;
    logic [2*XLEN:0]   mul_step, div_step;
    logic [2*XLEN-1:0] prod, prod_s;
    assign sgn_b  = bus.funct3_i == 3'd1 || bus.funct3_i == 3'd4 || bus.funct3_i == 3'd6;
    assign sgn_a  = sgn_b || bus.funct3_i == 3'd2;
    assign neg_a  = sgn_a & bus.src_a_i[XLEN-1];
    assign neg_b  = sgn_b & bus.src_b_i[XLEN-1];
    assign mag_a  = neg_a ? -bus.src_a_i : bus.src_a_i;
    assign mag_b  = neg_b ? -bus.src_b_i : bus.src_b_i;
    assign accept = state_q == IDLE && bus.start_i && !bus.flush_i;
    always_comb begin
        state_d = state_q;
        state_d = bus.flush_i      ? IDLE :
                  state_q == IDLE  ? (bus.start_i ? CALC : IDLE) :
                  state_q == CALC  ? (cnt_q == '0 ? FIX : CALC) :
                  state_q == FIX   ? DONE : IDLE;
    end
    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    always_comb begin
        mul_sum  = acc_q[2*XLEN:XLEN] + {1'b0, acc_q[0] ? m_q : '0};
        mul_step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        r_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = {1'b0, r_sh} - {2'b0, m_q};
        ge       = ~diff[XLEN+1];
        div_step = {ge ? diff[XLEN:0] : r_sh, acc_q[XLEN-2:0], ge};
    end
    // A zero divisor yields all-ones quotient and leaves the dividend as remainder.
    always_comb begin
        prod   = acc_q[2*XLEN-1:0];
        quo    = acc_q[XLEN-1:0];
        rem    = acc_q[2*XLEN-1:XLEN];
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_s  = m_q == '0 ? '1 : (neg_a_q ^ neg_b_q) ? -quo : quo;
        rem_s  = neg_a_q ? -rem : rem;
        res    = op_q[2] ? (op_q[1] ? rem_s : quo_s) :
                 op_q == 3'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= bus.funct3_i;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
                m_q     <= bus.funct3_i[2] ? mag_b : mag_a;
                acc_q   <= {{(XLEN+1){1'b0}}, bus.funct3_i[2] ? mag_a : mag_b};
                cnt_q   <= CW'(XLEN-1);
            end else if (state_q == CALC && !bus.flush_i) begin
                acc_q <= op_q[2] ? div_step : mul_step;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == FIX && !bus.flush_i) result_q <= res;
        end
    end
    assign bus.busy_o   = state_q == CALC || state_q == FIX;
    assign bus.done_o   = state_q == DONE;
    assign bus.stall_o  = bus.busy_o || (state_q == IDLE && bus.start_i);
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors, handshake corner cases and random ops checked
// against an arithmetic reference of the RV32M semantics.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0, n_total = 0, cyc = 0;
    muldiv_seq_if #(.XLEN(32)) bus();
    muldiv_seq #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        string       nm;
        logic [2:0]  f;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vecs[10];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
                if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
                if (!f[0]) return f[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
                return f[1] ? a % b : a / b;
            end
        endcase
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.funct3_i = f;
        bus.src_a_i  = a;
        bus.src_b_i  = b;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
    endtask
    task automatic wait_done(output int at);
        while (!bus.done_o && cyc < 200) tick();
        at = bus.done_o ? cyc : -1;
    endtask
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit full);
        int at;
        cyc = 0;
        launch(f, a, b);
        wait_done(at);
        chk({nm, "_result"}, bus.result_o, exp);
        chk({nm, "_latency"}, at, 34);
        tick();
        if (full) chk({nm, "_done_pulse"}, 32'(bus.done_o), 0);
    endtask
    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int at, bad;
        logic [2:0]  f;
        logic [31:0] a, b, prev;
        vecs[0] = '{"mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1] = '{"mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{"mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[3] = '{"mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{"div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5] = '{"rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6] = '{"divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7] = '{"remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8] = '{"div_by_zero",  3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9] = '{"rem_by_zero",  3'd6, 32'd5,          32'd0,         32'd5};
        bus.start_i = 0; bus.flush_i = 0; bus.funct3_i = 0; bus.src_a_i = 0; bus.src_b_i = 0;
        #3;
        chk("reset_busy", 32'(bus.busy_o), 0);
        chk("reset_done", 32'(bus.done_o), 0);
        chk("reset_stall", 32'(bus.stall_o), 0);
        chk("reset_result", bus.result_o, 0);
        #10 reset = 1'b0;
        tick();
        // Stall must cover the accept cycle through FIX and drop in DONE.
        bad = 0;
        cyc = 0;
        bus.funct3_i = 3'd0; bus.src_a_i = 32'd7; bus.src_b_i = 32'hFFFF_FFFD; bus.start_i = 1'b1;
        #1;
        if (!bus.stall_o) bad++;
        tick();
        bus.start_i = 1'b0;
        while (!bus.done_o && cyc < 200) begin
            if (bus.stall_o !== (cyc <= 33) || bus.busy_o !== (cyc <= 33)) bad++;
            tick();
        end
        if (bus.stall_o) bad++;
        chk("mul_stall_profile", bad, 0);
        chk("mul_done_cycle", cyc, 34);
        chk("mul_result", bus.result_o, 32'hFFFF_FFEB);
        tick();
        chk("mul_done_one_cycle", 32'(bus.done_o), 0);
        for (int i = 0; i < 10; i++) run_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        // Start during CALC with different operands must not disturb the op in flight.
        cyc = 0;
        launch(3'd5, 32'd100, 32'd7);
        while (cyc < 5) tick();
        bus.funct3_i = 3'd0; bus.src_a_i = 32'd3; bus.src_b_i = 32'd4; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("hold_result_mid_calc", bus.result_o, 32'd0);
        wait_done(at);
        chk("ignored_start_result", bus.result_o, 32'd14);
        chk("ignored_start_latency", at, 34);
        tick();
        prev = 32'd14;
        // Flush at cycle 10 aborts; a new start at 12 completes at 46.
        cyc = 0;
        launch(3'd0, 32'd9, 32'd9);
        while (cyc < 10) tick();
        bus.flush_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        chk("flush_busy", 32'(bus.busy_o), 0);
        chk("flush_done", 32'(bus.done_o), 0);
        chk("flush_result_kept", bus.result_o, prev);
        tick();
        chk("flush_no_done", 32'(bus.done_o), 0);
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(at);
        chk("after_flush_done_cycle", at, 46);
        chk("after_flush_result", bus.result_o, 32'hFFFF_FFFE);
        tick();
        // Asynchronous reset between edges clears outputs immediately.
        cyc = 0;
        launch(3'd4, 32'd77, 32'd3);
        while (cyc < 12) tick();
        #3 reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy_o), 0);
        chk("async_rst_done", 32'(bus.done_o), 0);
        chk("async_rst_result", bus.result_o, 0);
        #1 reset = 1'b0;
        tick();
        run_op("post_reset_mul", 3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, model(f, a, b), 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
